// File: rtl/logistic_pkg.sv
// Shared types and constants for the logistic oscillator scheduler.
// FSM encoding, operand width, default r values and the seed formula.
package logistic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam int DEF_R_BASE = 233964;
  localparam int DEF_R_INC  = 650;

  function automatic int calc_w(input int frac);
    return frac + 2;
  endfunction

  // x[i] = 0.25 + i/256 in Q0.FRAC
  function automatic int seed_val(input int frac, input int i);
    return (1 << (frac - 2)) + i * (1 << (frac - 8));
  endfunction

endpackage

// File: rtl/logistic_osc_scheduler_mult.sv
// Radix-2 shift-add multiplier: start/a/b in, done/product out.
// Done rises W cycles after the start cycle; start is ignored while busy.
module shift_add_mult #(
  parameter int W = 18
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  // First partial product is folded into the load edge so the
  // remaining W-1 iterations finish with done in the W-th cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end else if (start) begin
        product <= b[0] ? {{W{1'b0}}, a} : '0;
        mcand   <= {{(W-1){1'b0}}, a, 1'b0};
        mplier  <= {1'b0, b[W-1:1]};
        cnt     <= CW'(W - 1);
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/logistic_osc_scheduler.sv
// Iterates N_OSC logistic maps through one shared multiplier per step
// and mixes their states into a 1-bit square-wave output (snd).
// Ports: clk, reset (async high), step in; busy, pass_done,
// overrun (sticky), snd out.
module logistic_osc_scheduler
  import logistic_pkg::*;
#(
  parameter int N_OSC      = 8,
  parameter int FRAC       = 16,
  parameter int R_BASE     = DEF_R_BASE,
  parameter int R_INC      = DEF_R_INC,
  parameter int PHASE_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic busy,
  output logic pass_done,
  output logic overrun,
  output logic snd
);

  localparam int W  = calc_w(FRAC);
  localparam int IW = $clog2(N_OSC);
  localparam logic [IW-1:0] LAST = IW'(N_OSC - 1);
  localparam logic [W-1:0]  ONE  = W'(1) << FRAC;

  state_t              state;
  logic [IW-1:0]       idx;
  logic                pending;
  logic [FRAC-1:0]     x [N_OSC];
  logic [FRAC-1:0]     a1;
  logic [FRAC+3:0]     p;
  logic [FRAC-1:0]     x_new;
  logic [PHASE_BITS-1:0] phase [N_OSC];

  logic [W-1:0]   m_a;
  logic [W-1:0]   m_b;
  logic           m_start;
  logic           m_busy;
  logic           m_done;
  logic [2*W-1:0] m_product;

  logic [31:0] r_full;
  logic [W-1:0] r_cur;
  logic        last_wb;
  logic        snd_next;
  logic        unused_bits;

  assign r_full  = 32'(R_BASE) + 32'(idx) * 32'(R_INC);
  assign r_cur   = r_full[W-1:0];
  assign last_wb = (state == WB) && (idx == LAST);

  always_comb begin
    m_a = '0;
    m_b = '0;
    unique case (state)
      MUL1: begin
        m_a = {2'b00, x[idx]};
        m_b = ONE - {2'b00, x[idx]};
      end
      MUL2: begin
        m_a = r_cur;
        m_b = {2'b00, a1};
      end
      default: begin
        m_a = '0;
        m_b = '0;
      end
    endcase
  end

  // Kick only in the first cycle of a MUL state: not yet running,
  // and not the done cycle of the previous operation.
  assign m_start = ((state == MUL1) || (state == MUL2))
                 && !m_busy && !m_done;

  shift_add_mult #(.W(W)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (m_start),
    .a       (m_a),
    .b       (m_b),
    .busy    (m_busy),
    .done    (m_done),
    .product (m_product)
  );

  always_comb begin
    x_new = p[FRAC-1:0];
    if (|p[FRAC+3:FRAC]) x_new = '1;
    if (x_new == '0) x_new = FRAC'(seed_val(FRAC, int'(idx)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      overrun   <= 1'b0;
      a1        <= '0;
      p         <= '0;
      for (int i = 0; i < N_OSC; i++)
        x[i] <= FRAC'(seed_val(FRAC, i));
    end else begin
      pass_done <= 1'b0;
      case (state)
        IDLE: begin
          if (step || pending) begin
            pending <= 1'b0;
            idx     <= '0;
            state   <= MUL1;
            busy    <= 1'b1;
          end
        end
        MUL1: begin
          if (m_done) begin
            a1    <= m_product[2*FRAC-1:FRAC];
            state <= MUL2;
          end
        end
        MUL2: begin
          if (m_done) begin
            p         <= m_product[2*W-1:FRAC];
            state     <= WB;
            pass_done <= (idx == LAST);
          end
        end
        WB: begin
          x[idx] <= x_new;
          if (idx != LAST) begin
            idx   <= idx + 1'b1;
            state <= MUL1;
          end else if (pending || step) begin
            // a step landing here chains straight into the next pass
            idx     <= '0;
            pending <= 1'b0;
            state   <= MUL1;
            if (pending && step) overrun <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (state != IDLE && !last_wb && step) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

  always_comb begin
    snd_next = 1'b0;
    for (int i = 0; i < N_OSC; i++)
      snd_next = snd_next ^ phase[i][PHASE_BITS-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snd <= 1'b0;
      for (int i = 0; i < N_OSC; i++)
        phase[i] <= '0;
    end else begin
      snd <= snd_next;
      for (int i = 0; i < N_OSC; i++)
        phase[i] <= phase[i]
          + PHASE_BITS'({1'b0, x[i][FRAC-1:FRAC-4]} + 5'd1);
    end
  end

  assign unused_bits = ^{m_product[FRAC-1:0], r_full[31:W]};

endmodule

// File: tb/tb_logistic_osc_scheduler.sv
// Scoreboard bench for logistic_osc_scheduler.
// Stimulus pushes expected pass_done events; a monitor pops them.
module tb_logistic_osc_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic step = 1'b0;
  logic step0 = 1'b0;
  logic busy, pass_done, overrun, snd;
  logic busy0, pass_done0, overrun0, snd0;

  logistic_osc_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .busy      (busy),
    .pass_done (pass_done),
    .overrun   (overrun),
    .snd       (snd)
  );

  logistic_osc_scheduler #(.R_BASE(0), .R_INC(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .step      (step0),
    .busy      (busy0),
    .pass_done (pass_done0),
    .overrun   (overrun0),
    .snd       (snd0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int x0;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  int pd_cnt = 0;
  int pd0_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int lmap(input int x, input int r, input int i);
    longint unsigned a1, pr;
    a1 = ((longint'(x) * longint'(65536 - x)) >> 16) & 64'hFFFF;
    pr = (longint'(r) * a1) >> 16;
    if (pr > 65535) pr = 65535;
    if (pr == 0) pr = 16384 + i * 256;
    return int'(pr);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (pass_done0) pd0_cnt++;
    if (pass_done) begin
      pd_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected pass_done", cyc, -1);
      end else begin
        e = sb.pop_front();
        chk("pass_done cycle", cyc, e.cyc);
        chk("x0 after pass", dut.x[0], e.x0);
      end
    end
  end

  task automatic step_at(input int t);
    while (cyc < t) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk(name, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s, bb, pb, viol;
    int x1;
    x1 = lmap(16'hAB5C, 233964, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    viol = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || snd !== 1'b0) viol++;
    end
    chk("idle busy/snd", viol, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("phase[%0d]", i), dut.phase[i], 500);

    @(negedge clk);
    bb = busy_cnt;
    pb = pd_cnt;
    s = cyc;
    sb.push_back('{s + 312, 'hAB5C});
    step = 1'b1;
    step0 = 1'b1;
    @(negedge clk);
    step = 1'b0;
    step0 = 1'b0;
    wait_idle(1000, "single pass timeout");
    chk("single pass busy", busy_cnt - bb, 312);
    chk("single pass count", pd_cnt - pb, 1);
    chk("single overrun", overrun, 0);
    chk("zero-r pass count", pd0_cnt, 1);
    chk("zero-r overrun", overrun0, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("reseed x[%0d]", i), dut0.x[i], 16384 + i * 256);

    do_reset();
    @(negedge clk);
    bb = busy_cnt;
    s = cyc;
    sb.push_back('{s + 312, 'hAB5C});
    sb.push_back('{s + 624, x1});
    step_at(s);
    step_at(s + 50);
    chk("pending no overrun", overrun, 0);
    step_at(s + 100);
    chk("third step overrun", overrun, 1);
    wait_idle(1500, "double pass timeout");
    chk("double pass busy", busy_cnt - bb, 624);
    chk("overrun sticky", overrun, 1);

    do_reset();
    chk("overrun cleared", overrun, 0);
    @(negedge clk);
    bb = busy_cnt;
    s = cyc;
    sb.push_back('{s + 312, 'hAB5C});
    sb.push_back('{s + 624, x1});
    step_at(s);
    step_at(s + 312);
    wait_idle(1500, "chained pass timeout");
    chk("chained pass busy", busy_cnt - bb, 624);
    chk("chained overrun", overrun, 0);

    do_reset();
    @(negedge clk);
    s = cyc;
    sb.push_back('{s + 312, 'hAB5C});
    step_at(s);
    while (cyc < s + 150) @(negedge clk);
    chk("busy before reset", busy, 1);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("busy async reset", busy, 0);
    chk("x0 async reset", dut.x[0], 'h4000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bb = busy_cnt;
    s = cyc;
    sb.push_back('{s + 312, 'hAB5C});
    step_at(s);
    wait_idle(1000, "post-reset pass timeout");
    chk("post-reset busy", busy_cnt - bb, 312);

    repeat (3) @(negedge clk);
    chk("scoreboard empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
